bitblt_mul_arbiter: RTL and testbench
=====================================

BITBLT_MUL_ARBITER -- requirements
Module: bitblt_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter IDW, default 2, requester-index width, equal to clog2(NREQ).
REQ-003 ap_clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 ap_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NREQ  per-requester operand-valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit is high per cycle.
REQ-007 req_a  input  8*NREQ  unsigned operand A, slice i belongs to requester i.
REQ-008 req_b  input  8*NREQ  unsigned operand B, slice i belongs to requester i.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  downstream accepts the result.
REQ-011 rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 rsp_data  output  16  unsigned product A*B.
REQ-013 inflight  output  2  number of occupied pipeline stages (0..2).

Function
REQ-014 A transfer occurs on a requester port when req_valid[i] and req_ready[i] are both high at a clock edge; the result port uses the same rule with rsp_valid/rsp_ready.
REQ-015 Pipeline has two stages: S1 holds {a, b, id}; S2 holds {product, id}; S2 drives rsp_*.
REQ-016 S2 loads when S1 is full and (S2 is empty or the result transfers); S2 empties on a result transfer with no reload.
REQ-017 S1 accepts when S1 is empty or S1 moves to S2 in the same cycle.
REQ-018 Latency: accept at edge N gives rsp_valid high after edge N+1 when rsp_ready is held high; sustained throughput is one result per cycle.
REQ-019 Arbitration is round-robin: among asserted req_valid, grant the lowest index strictly above last_grant, wrapping from NREQ-1 to 0.
REQ-020 last_grant updates only on an accepted transfer; a grant that is not accepted leaves the pointer unchanged.
REQ-021 req_ready[i] = grant[i] AND S1-accept; it depends combinationally on req_valid, which must never depend on req_ready.
REQ-022 Product is the full 16-bit unsigned result, so 255*255 gives 0xFE01; there is no truncation or sign extension.
REQ-023 Backpressure: while rsp_valid is high and rsp_ready is low, rsp_id and rsp_data hold stable, and once S1 is also full all req_ready are low.
REQ-024 inflight = S1-full + S2-full, updated every cycle.
REQ-025 When a single requester is valid, it is granted every cycle without a starvation penalty.
REQ-026 With no req_valid asserted, all req_ready are low and the pipeline drains normally.

Reset
REQ-027 Asserting ap_rst_n low clears S1-full and S2-full, forces rsp_valid=0, rsp_id=0, rsp_data=0 and inflight=0, and sets last_grant=NREQ-1 so that requester 0 is first.
REQ-028 Reset taken in the middle of an operation discards in-flight operands and results without producing a response, and req_ready is low while reset is held.
REQ-029 On the first edge after deassertion the block may accept a request.

Structure
REQ-030 NREQ/IDW defaults and the rr-grant function signature live in a shared package bitblt_pkg.
REQ-031 The product is computed by the existing bitblt_mul_8ns_8ns_16_1_1 instance, fed from S1.
REQ-032 One new sub-module, bitblt_rr_pick, is natural: a combinational round-robin picker with inputs valid[NREQ] and last[IDW] and outputs grant[NREQ] and grant_id[IDW].

Verification
REQ-033 The bench shall cover reset: release reset and drive req0 with a=3, b=5. Response: rsp_valid is high two edges later with rsp_id=0 and rsp_data=15.
REQ-034 The bench shall cover the maximum operands: a=255, b=255. Response: rsp_data=0xFE01.
REQ-035 The bench shall cover round-robin fairness: all 4 requesters valid continuously with rsp_ready=1. Response: grant order is 0,1,2,3,0,...; each result appears one per cycle with the matching id; inflight=2 in steady state.
REQ-036 The bench shall cover backpressure: hold rsp_ready=0 for 5 cycles with 2 requesters valid. Response: exactly 2 accepts occur, then all req_ready are low; rsp_data is stable; after release the results emerge in accept order with no loss or duplication.
REQ-037 The bench shall cover pointer hold: req2 is valid but S1 is blocked. Response: last_grant stays unchanged; after unblocking, req2 is served before req3.
REQ-038 The bench shall cover mid-operation reset: pulse ap_rst_n low with inflight=2. Response: rsp_valid and inflight go to 0 immediately, and no stale response appears after reset release.

Source files
------------

// File: rtl/bitblt_pkg.sv
// Shared definitions for the bitblt multiply arbiter: default sizing, the
// stage-1 operand record and the round-robin grant function.
package bitblt_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
  localparam int NREQ_MAX = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } operand_t;

  // One-hot grant of the first valid index strictly above last, wrapping at nreq.
  function automatic logic [NREQ_MAX-1:0] rr_grant(input logic [NREQ_MAX-1:0] valid,
                                                   input logic [2:0]          last,
                                                   input int                  nreq);
    logic [NREQ_MAX-1:0] grant;
    logic                found;
    int                  idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      idx = (int'(last) + k) % nreq;
      if (k <= nreq && !found && valid[3'(idx)]) begin
        grant[3'(idx)] = 1'b1;
        found          = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bitblt_mul_8ns_8ns_16_1_1.sv
// Combinational 8x8 unsigned multiplier with a full 16-bit product.
module bitblt_mul_8ns_8ns_16_1_1 (
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  output logic [15:0] dout
);

  assign dout = 16'(din0) * 16'(din1);

endmodule

// File: rtl/bitblt_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus its binary index.
module bitblt_rr_pick
  import bitblt_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [NREQ_MAX-1:0] valid_w;
  logic [NREQ_MAX-1:0] grant_w;

  always_comb begin
    valid_w = '0;
    for (int i = 0; i < NREQ; i++) valid_w[i] = valid[i];
    grant_w = rr_grant(valid_w, 3'(last), NREQ);
  end

  // Bits at or above NREQ are never set by rr_grant, so scanning all of them is harmless.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) grant[i] = grant_w[i];
    for (int i = 0; i < NREQ_MAX; i++) begin
      if (grant_w[i]) grant_id = IDW'(i);
    end
  end

endmodule

// File: rtl/bitblt_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage multiply pipeline: S1 holds
// operands, S2 holds the product and drives the response port.
module bitblt_mul_arbiter
  import bitblt_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
  output logic [1:0]        inflight
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic            s1_full_q, s1_full_d;
  operand_t        s1_op_q, s1_op_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_full_q, s2_full_d;
  logic [15:0]     s2_data_q, s2_data_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic            rsp_fire, s2_load, s1_accept, req_fire;
  operand_t        req_op;
  logic [15:0]     product;

  bitblt_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid    (req_valid),
    .last     (last_grant_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  bitblt_mul_8ns_8ns_16_1_1 u_mul (
    .din0 (s1_op_q.a),
    .din1 (s1_op_q.b),
    .dout (product)
  );

  // Ready is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    rsp_fire  = s2_full_q & rsp_ready;
    s2_load   = s1_full_q & (~s2_full_q | rsp_fire);
    s1_accept = ~s1_full_q | s2_load;
    req_ready = ap_rst_n ? (grant & {NREQ{s1_accept}}) : '0;
    req_fire  = |(req_valid & req_ready);
  end

  always_comb begin
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) req_op = '{a: req_a[8*i +: 8], b: req_b[8*i +: 8]};
    end
  end

  always_comb begin
    s1_full_d    = req_fire | (s1_full_q & ~s2_load);
    s1_op_d      = req_fire ? req_op : s1_op_q;
    s1_id_d      = req_fire ? grant_id : s1_id_q;
    s2_full_d    = s2_load | (s2_full_q & ~rsp_fire);
    s2_data_d    = s2_load ? product : s2_data_q;
    s2_id_d      = s2_load ? s1_id_q : s2_id_q;
    last_grant_d = req_fire ? grant_id : last_grant_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_full_q    <= 1'b0;
      s1_op_q      <= '0;
      s1_id_q      <= '0;
      s2_full_q    <= 1'b0;
      s2_data_q    <= '0;
      s2_id_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      s1_full_q    <= s1_full_d;
      s1_op_q      <= s1_op_d;
      s1_id_q      <= s1_id_d;
      s2_full_q    <= s2_full_d;
      s2_data_q    <= s2_data_d;
      s2_id_q      <= s2_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = s2_full_q;
  assign rsp_id    = s2_id_q;
  assign rsp_data  = s2_data_q;
  assign inflight  = {1'b0, s1_full_q} + {1'b0, s2_full_q};

endmodule

// File: tb/tb_bitblt_mul_arbiter.sv
// Directed bench for bitblt_mul_arbiter: hand-computed grants, products and
// pipeline occupancy across reset, round-robin, backpressure and pointer hold.
module tb_bitblt_mul_arbiter;

  logic        ap_clk;
  logic        ap_rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic [1:0]  inflight;

  int passCount;
  int checkCount;
  int accepts;
  logic [15:0] rrProd [4];
  logic [3:0]  expReady;

  bitblt_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .inflight  (inflight)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic stepClk();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
    #1;
  endtask

  task automatic setOperands(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
  endtask

  task automatic doReset();
    ap_rst_n = 1'b0;
    stepClk();
    stepClk();
    ap_rst_n = 1'b1;
    #1;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    ap_rst_n   = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b1;

    // Reset state, with req0 already asking for 3*5.
    setOperands(0, 8'd3, 8'd5);
    applyStimulus(4'b0001, 1'b1);
    stepClk();
    stepClk();
    checkOutput("rst_valid", rsp_valid, 0);
    checkOutput("rst_inflight", inflight, 0);
    checkOutput("rst_data", rsp_data, 0);
    checkOutput("rst_id", rsp_id, 0);
    checkOutput("rst_ready_held", req_ready, 0);

    ap_rst_n = 1'b1;
    #1;
    checkOutput("first_ready", req_ready, 4'b0001);
    stepClk();
    checkOutput("first_inflight", inflight, 1);
    checkOutput("first_valid_early", rsp_valid, 0);
    applyStimulus(4'b0000, 1'b1);
    stepClk();
    checkOutput("first_valid", rsp_valid, 1);
    checkOutput("first_id", rsp_id, 0);
    checkOutput("first_data", rsp_data, 15);
    stepClk();
    checkOutput("first_drain", rsp_valid, 0);

    // Maximum operands; a lone requester is granted again immediately.
    setOperands(0, 8'd255, 8'd255);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("max_ready", req_ready, 4'b0001);
    stepClk();
    applyStimulus(4'b0000, 1'b1);
    stepClk();
    checkOutput("max_id", rsp_id, 0);
    checkOutput("max_data", rsp_data, 16'hFE01);
    stepClk();
    checkOutput("max_drain", rsp_valid, 0);

    // Round-robin with everyone valid; reset first so requester 0 leads.
    rrProd[0] = 16'd10;
    rrProd[1] = 16'd22;
    rrProd[2] = 16'd36;
    rrProd[3] = 16'd52;
    for (int i = 0; i < 4; i++) setOperands(i, 8'(i + 1), 8'(10 + i));
    applyStimulus(4'b0000, 1'b1);
    doReset();
    applyStimulus(4'b1111, 1'b1);
    for (int cyc = 0; cyc < 10; cyc++) begin
      expReady = 4'b0001 << (cyc % 4);
      checkOutput("rr_ready", req_ready, expReady);
      if (cyc == 1) checkOutput("rr_fill", inflight, 1);
      if (cyc >= 2) begin
        checkOutput("rr_valid", rsp_valid, 1);
        checkOutput("rr_id", rsp_id, (cyc - 2) % 4);
        checkOutput("rr_data", rsp_data, rrProd[(cyc - 2) % 4]);
        checkOutput("rr_inflight", inflight, 2);
      end
      stepClk();
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rr_tail_id0", rsp_id, 0);
    checkOutput("rr_tail_data0", rsp_data, 10);
    stepClk();
    checkOutput("rr_tail_id1", rsp_id, 1);
    checkOutput("rr_tail_data1", rsp_data, 22);
    stepClk();
    checkOutput("rr_empty", rsp_valid, 0);

    // Backpressure: pointer sits at 1, so req2 then req0 are taken.
    setOperands(0, 8'd7, 8'd9);
    setOperands(2, 8'd11, 8'd13);
    applyStimulus(4'b0101, 1'b0);
    accepts = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if ((req_valid & req_ready) != 0) accepts++;
      if (cyc == 0) checkOutput("bp_grant0", req_ready, 4'b0100);
      if (cyc == 1) checkOutput("bp_grant1", req_ready, 4'b0001);
      if (cyc >= 2) begin
        checkOutput("bp_blocked", req_ready, 0);
        checkOutput("bp_hold_id", rsp_id, 2);
        checkOutput("bp_hold_data", rsp_data, 143);
      end
      stepClk();
    end
    checkOutput("bp_accepts", accepts, 2);
    checkOutput("bp_inflight", inflight, 2);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("bp_out0_id", rsp_id, 2);
    checkOutput("bp_out0_data", rsp_data, 143);
    stepClk();
    checkOutput("bp_out1_id", rsp_id, 0);
    checkOutput("bp_out1_data", rsp_data, 63);
    stepClk();
    checkOutput("bp_no_dup", rsp_valid, 0);
    checkOutput("bp_empty", inflight, 0);

    // Pointer hold: fill with req1, then req2/req3 wait on a blocked S1.
    setOperands(1, 8'd2, 8'd3);
    setOperands(2, 8'd4, 8'd5);
    setOperands(3, 8'd6, 8'd7);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("ph_fill0", req_ready, 4'b0010);
    stepClk();
    checkOutput("ph_fill1", req_ready, 4'b0010);
    stepClk();
    applyStimulus(4'b1100, 1'b0);
    for (int cyc = 0; cyc < 3; cyc++) begin
      checkOutput("ph_blocked", req_ready, 0);
      stepClk();
    end
    applyStimulus(4'b1100, 1'b1);
    checkOutput("ph_req2_first", req_ready, 4'b0100);
    checkOutput("ph_out0_id", rsp_id, 1);
    stepClk();
    checkOutput("ph_req3_next", req_ready, 4'b1000);
    checkOutput("ph_out1_id", rsp_id, 1);
    checkOutput("ph_out1_data", rsp_data, 6);
    stepClk();
    applyStimulus(4'b0000, 1'b1);
    checkOutput("ph_out2_id", rsp_id, 2);
    checkOutput("ph_out2_data", rsp_data, 20);
    stepClk();
    checkOutput("ph_out3_id", rsp_id, 3);
    checkOutput("ph_out3_data", rsp_data, 42);
    stepClk();
    checkOutput("ph_empty", rsp_valid, 0);

    // Mid-operation reset with both stages full.
    setOperands(0, 8'd9, 8'd9);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("mr_ready", req_ready, 4'b0001);
    stepClk();
    stepClk();
    checkOutput("mr_full", inflight, 2);
    checkOutput("mr_valid_pre", rsp_valid, 1);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("mr_valid_now", rsp_valid, 0);
    checkOutput("mr_inflight_now", inflight, 0);
    checkOutput("mr_data_now", rsp_data, 0);
    checkOutput("mr_ready_held", req_ready, 0);
    applyStimulus(4'b0000, 1'b1);
    stepClk();
    ap_rst_n = 1'b1;
    #1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      stepClk();
      checkOutput("mr_no_stale", rsp_valid, 0);
      checkOutput("mr_idle", inflight, 0);
    end
    applyStimulus(4'b1001, 1'b1);
    checkOutput("mr_ptr_reset", req_ready, 4'b0001);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
